alu_wb_stage: RTL and testbench

- Execute/write-back stage directly downstream of reg_file.
- Consumes the two register read values and an opcode, and computes the result.
  - Single-cycle ops: add, sub, and, or, xor, shifts.
  - Multi-cycle op: sequential shift-add multiply.
- Drives the reg_file write port (wen, address, level, data) for exactly one cycle per operation.
- Valid/ready handshake on the upstream side.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_wb_stage.sv | 145 ++++++++++++++
 tb/tb_alu_wb_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU write-back stage.
// Opcode encodings, FSM states and the opcode width.
package alu_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per cycle.
// Ports: clk, reset, start (load a/b), a, b, done (last cycle), product.
module alu_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic                    run;
  logic [CW-1:0]           cnt;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [2*DATA_WIDTH-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // product includes the final iteration so the
  // parent can latch it on the same edge as done
  assign product = acc_next;
  assign done    = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{DATA_WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/write-back stage: single-cycle ALU ops plus a sequential
// multiply; ports: valid/ready in, reg_file write port and flags out.
module alu_wb_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs_val_i,
  input  logic [DATA_WIDTH-1:0] rt_val_i,
  input  logic [ADDR_WIDTH-1:0] dest_addr_i,
  input  logic                  level_i,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic                  level_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  zero_o,
  output logic                  carry_o,
  output logic                  busy_o
);

  import alu_pkg::*;

  state_t state_q;
  state_t state_d;
  op_t    op_in;

  logic                    accept;
  logic                    mul_start;
  logic                    mul_done;
  logic [2*DATA_WIDTH-1:0] product;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic [DATA_WIDTH:0]   wide;
  logic [2:0]            shamt;

  assign op_in     = op_t'(op_i);
  assign accept    = valid_i && (state_q == IDLE);
  assign mul_start = accept && (op_in == OP_MUL);
  assign shamt     = rt_val_i[2:0];

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q != IDLE);
  assign wen_o   = (state_q == WB);

  alu_mul_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (rs_val_i),
    .b       (rt_val_i),
    .done    (mul_done),
    .product (product)
  );

  // Extra top/bottom bit of wide catches carry,
  // borrow, or the last bit shifted out.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op_in)
      OP_ADD: begin
        wide    = {1'b0, rs_val_i} + {1'b0, rt_val_i};
        alu_res = wide[DATA_WIDTH-1:0];
        alu_c   = wide[DATA_WIDTH];
      end
      OP_SUB: begin
        wide    = {1'b0, rs_val_i} - {1'b0, rt_val_i};
        alu_res = wide[DATA_WIDTH-1:0];
        alu_c   = wide[DATA_WIDTH];
      end
      OP_AND: alu_res = rs_val_i & rt_val_i;
      OP_OR:  alu_res = rs_val_i | rt_val_i;
      OP_XOR: alu_res = rs_val_i ^ rt_val_i;
      OP_SHL: begin
        wide    = {1'b0, rs_val_i} << shamt;
        alu_res = wide[DATA_WIDTH-1:0];
        alu_c   = wide[DATA_WIDTH];
      end
      OP_SHR: begin
        wide    = {rs_val_i, 1'b0} >> shamt;
        alu_res = wide[DATA_WIDTH:1];
        alu_c   = wide[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i)
          state_d = (op_in == OP_MUL) ? MUL : WB;
      end
      MUL: begin
        if (mul_done) state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results latch on the edge that enters WB and
  // hold until the next write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_o      <= '0;
      level_o      <= 1'b0;
      write_data_o <= '0;
      zero_o       <= 1'b0;
      carry_o      <= 1'b0;
    end else begin
      if (accept) begin
        waddr_o <= dest_addr_i;
        level_o <= level_i;
      end
      if (accept && (op_in != OP_MUL)) begin
        write_data_o <= alu_res;
        carry_o      <= alu_c;
        zero_o       <= (alu_res == '0);
      end else if ((state_q == MUL) && mul_done) begin
        write_data_o <= product[DATA_WIDTH-1:0];
        carry_o      <= |product[2*DATA_WIDTH-1:DATA_WIDTH];
        zero_o       <= (product[DATA_WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Testbench for alu_wb_stage: directed vectors, random ops
// against an arithmetic model, back-pressure and reset abort.
module tb_alu_wb_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic       ready_o;
  logic [2:0] op_i;
  logic [7:0] rs_val_i;
  logic [7:0] rt_val_i;
  logic [1:0] dest_addr_i;
  logic       level_i;
  logic       wen_o;
  logic [1:0] waddr_o;
  logic       level_o;
  logic [7:0] write_data_o;
  logic       zero_o;
  logic       carry_o;
  logic       busy_o;

  always #5 clk = ~clk;

  alu_wb_stage #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .op_i         (op_i),
    .rs_val_i     (rs_val_i),
    .rt_val_i     (rt_val_i),
    .dest_addr_i  (dest_addr_i),
    .level_i      (level_i),
    .wen_o        (wen_o),
    .waddr_o      (waddr_o),
    .level_o      (level_o),
    .write_data_o (write_data_o),
    .zero_o       (zero_o),
    .carry_o      (carry_o),
    .busy_o       (busy_o)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] d;
    logic       l;
    logic [7:0] data;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Returns {zero, carry, data[7:0]}
  function automatic logic [9:0] model(
    input logic [2:0] op, input int a, input int b);
    int r;
    int c;
    int s;
    s = b & 7;
    c = 0;
    r = 0;
    case (op)
      3'd0: begin r = a + b; c = (r > 255) ? 1 : 0; end
      3'd1: begin r = a - b; c = (a < b) ? 1 : 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a << s;
        c = (s == 0) ? 0 : ((a >> (8 - s)) & 1);
      end
      3'd6: begin
        r = a >> s;
        c = (s == 0) ? 0 : ((a >> (s - 1)) & 1);
      end
      default: begin
        r = a * b;
        c = ((r >> 8) != 0) ? 1 : 0;
      end
    endcase
    r = r & 255;
    return {(r == 0), c[0], r[7:0]};
  endfunction

  task automatic run_op(input logic [2:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [1:0] d,
                        input logic       l,
                        input logic [9:0] exp,
                        input string      nm);
    int lat;
    @(negedge clk);
    chk({nm, " ready"}, ready_o, 1);
    valid_i     = 1'b1;
    op_i        = op;
    rs_val_i    = a;
    rt_val_i    = b;
    dest_addr_i = d;
    level_i     = l;
    @(negedge clk);
    valid_i  = 1'b0;
    op_i     = 3'($urandom);
    rs_val_i = 8'($urandom);
    rt_val_i = 8'($urandom);
    lat = 1;
    while (!wen_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, (op == 3'd7) ? 9 : 1);
    chk({nm, " result"},
        {zero_o, carry_o, write_data_o}, exp);
    chk({nm, " waddr"}, {level_o, waddr_o}, {l, d});
    @(negedge clk);
    chk({nm, " one-wen"}, {wen_o, ready_o}, 2'b01);
    chk({nm, " hold"},
        {zero_o, carry_o, write_data_o}, exp);
  endtask

  initial begin
    int wcount;
    int first;
    int second;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] w2;

    vecs[0] = '{3'd0, 8'hF0, 8'h20, 2'b01, 1'b1,
                8'h10, 1'b1, 1'b0};
    vecs[1] = '{3'd1, 8'h05, 8'h05, 2'b10, 1'b0,
                8'h00, 1'b0, 1'b1};
    vecs[2] = '{3'd1, 8'h03, 8'h05, 2'b11, 1'b1,
                8'hFE, 1'b1, 1'b0};
    vecs[3] = '{3'd7, 8'h0F, 8'h11, 2'b00, 1'b1,
                8'hFF, 1'b0, 1'b0};
    vecs[4] = '{3'd7, 8'h10, 8'h10, 2'b01, 1'b0,
                8'h00, 1'b1, 1'b1};
    vecs[5] = '{3'd5, 8'h81, 8'h01, 2'b10, 1'b1,
                8'h02, 1'b1, 1'b0};
    vecs[6] = '{3'd6, 8'h81, 8'h01, 2'b11, 1'b0,
                8'h40, 1'b1, 1'b0};
    vecs[7] = '{3'd5, 8'h81, 8'h08, 2'b01, 1'b1,
                8'h81, 1'b0, 1'b0};

    reset       = 1'b1;
    valid_i     = 1'b0;
    op_i        = 3'd0;
    rs_val_i    = 8'h00;
    rt_val_i    = 8'h00;
    dest_addr_i = 2'd0;
    level_i     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outs",
        {ready_o, busy_o, wen_o, waddr_o, level_o},
        6'b100000);
    chk("reset data",
        {zero_o, carry_o, write_data_o}, 10'h000);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].d, vecs[i].l,
             {vecs[i].z, vecs[i].c, vecs[i].data},
             $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = (i % 3 == 0) ? 8'($urandom_range(0, 9))
                        : 8'($urandom);
      run_op(op, a, b, 2'($urandom), 1'($urandom),
             model(op, int'(a), int'(b)),
             $sformatf("rnd%0d", i));
    end

    // Back-pressure: hold valid through a MUL
    @(negedge clk);
    valid_i     = 1'b1;
    op_i        = 3'd7;
    rs_val_i    = 8'h0F;
    rt_val_i    = 8'h11;
    dest_addr_i = 2'd2;
    level_i     = 1'b0;
    @(negedge clk);
    wcount = 0;
    first  = 0;
    second = 0;
    d1 = 8'h00;
    d2 = 8'h00;
    w2 = 3'd0;
    for (int k = 1; k <= 14; k++) begin
      if (wen_o) begin
        wcount++;
        if (first == 0) begin
          first = k;
          d1 = write_data_o;
        end else if (second == 0) begin
          second = k;
          d2 = write_data_o;
          w2 = {level_o, waddr_o};
        end
      end
      if (k < 9) begin
        op_i        = 3'($urandom);
        rs_val_i    = 8'($urandom);
        rt_val_i    = 8'($urandom);
        dest_addr_i = 2'($urandom);
      end else if (k == 9) begin
        op_i        = 3'd0;
        rs_val_i    = 8'h11;
        rt_val_i    = 8'h22;
        dest_addr_i = 2'd3;
        level_i     = 1'b1;
      end else if (k == 11) begin
        valid_i = 1'b0;
      end
      @(negedge clk);
    end
    chk("bp wen count", wcount, 2);
    chk("bp first cycle", first, 9);
    chk("bp first data", d1, 8'hFF);
    chk("bp next cycle", second, 11);
    chk("bp next data", d2, 8'h33);
    chk("bp next addr", w2, 3'b111);

    // Reset in the 4th MUL cycle aborts the op
    @(negedge clk);
    valid_i     = 1'b1;
    op_i        = 3'd7;
    rs_val_i    = 8'h0F;
    rt_val_i    = 8'h11;
    dest_addr_i = 2'd1;
    level_i     = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy", {busy_o, ready_o}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    chk("abort outs",
        {ready_o, busy_o, wen_o, waddr_o, level_o},
        6'b100000);
    chk("abort data",
        {zero_o, carry_o, write_data_o}, 10'h000);
    reset  = 1'b0;
    wcount = 0;
    for (int k = 0; k < 15; k++) begin
      if (wen_o) wcount++;
      @(negedge clk);
    end
    chk("abort no wen", wcount, 0);

    run_op(3'd4, 8'hA5, 8'h5A, 2'd2, 1'b0,
           model(3'd4, 'hA5, 'h5A), "post-abort");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
